spi_flash_responder: RTL and testbench
======================================

SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 8, meaning byte-array address width (2^MEM_AW bytes).
REQ-002 SHALL have parameter PROG_CYCLES, default 16, meaning busy cycles after a page program.
REQ-003 SHALL have port clk  input  1  the single clock; one SPI bit per rising edge while selected.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flash_cs  input  1  chip select, active low.
REQ-006 SHALL have port flash_si  input  1  serial command/address/data in (DQ0).
REQ-007 SHALL have port flash_dq_out  output  4  response lines; DQ1 carries single-line SO.
REQ-008 SHALL have port flash_dq_oe  output  1  high while flash_dq_out is driven.
REQ-009 SHALL have port busy  output  1  mirror of status WIP bit.

Function
REQ-010 SHALL sample flash_si MSB-first on each clk edge with flash_cs low; first 8 bits form the command.
REQ-011 SHALL use states IDLE, CMD, ADDR, DUMMY, READ, PROG, STATUS, IGNORE; flash_cs high forces IDLE on the next edge.
REQ-012 SHALL, for command 0x06 (WREN), set status WEL (bit1) when flash_cs rises, unless WIP.
REQ-013 SHALL, for command 0x04 (WRDI), clear WEL when flash_cs rises, unless WIP.
REQ-014 SHALL, for 0x05 (RDSR), drive status {6'b0,WEL,WIP} on DQ1 MSB-first, repeating each 8 bits, first bit in the cycle after the 8th command bit; accepted even while WIP.
REQ-015 SHALL, for 0x03 (READ), take 24 address bits, use low MEM_AW bits, drive mem[addr] bit7 on DQ1 in the cycle after the 24th address bit, auto-increment per byte, wrap 2^MEM_AW-1 -> 0.
REQ-016 SHALL, for 0x02 (PP) with WEL set, take 24 address bits, then on each complete data byte write mem[addr] <= mem[addr] AND data, increment addr with wrap.
REQ-017 SHALL, on flash_cs rise after PP with at least one full data byte, set WIP for PROG_CYCLES cycles and clear WEL.
REQ-018 SHALL, for 0xC7 (chip erase) with WEL set, on flash_cs rise set WIP, write 0xFF to one byte per cycle from address 0 to 2^MEM_AW-1, then clear WIP and WEL.
REQ-019 SHALL treat unknown commands, PP/0xC7 without WEL, and any command except 0x05 while WIP as IGNORE: no state change, flash_dq_oe low.
REQ-020 SHALL discard a partial byte when flash_cs rises mid-byte; a PP with zero full data bytes does not set WIP.
REQ-021 SHALL drive flash_dq_oe high only in READ/STATUS (and quad READ) data phases; flash_dq_out unused lines 0.
REQ-022 SHALL drop flash_dq_oe low on the first edge after flash_cs rises.

Reset
REQ-023 SHALL on reset return to IDLE, clear WIP, WEL, busy, flash_dq_oe, flash_dq_out, bit/address counters, and abort any program/erase.
REQ-024 SHALL preserve memory contents through reset; erase aborted mid-sweep leaves already-erased bytes at 0xFF.

Configuration
REQ-025 SHALL, with FLASH_RESP_QUAD_EN defined, support 0x6B (quad output read): 24 address bits, 8 dummy cycles, then one nibble per cycle on flash_dq_out[3:0], high nibble first, auto-increment with wrap.
REQ-026 SHALL, without FLASH_RESP_QUAD_EN, treat 0x6B as unknown (IGNORE) and never drive flash_dq_out[3:2,0].

Verification
REQ-027 SHALL cover: reset, RDSR -> DQ1 shows 0x00; WREN, RDSR -> 0x02.
REQ-028 SHALL cover: WREN, PP addr 0x00EEBB data 0x8C,0xEF, cs high -> busy high exactly 16 cycles; READ 0x00EEBB -> 0x8C,0xEF (addr wraps to 0xBB in 256-byte array).
REQ-029 SHALL cover: PP without WREN -> memory unchanged, WIP stays 0.
REQ-030 SHALL cover: READ from 0x0000FF for 2 bytes -> mem[0xFF] then mem[0x00].
REQ-031 SHALL cover: cs high after 5 data bits of PP -> no write, WIP 0; reset during erase -> busy 0 next cycle, READ still works.
REQ-032 SHALL cover (FLASH_RESP_QUAD_EN): 0x6B at 0x00EEBB after program -> nibbles 0x8,0xC,0xE,0xF starting 8 cycles after last address bit.

Source files
------------

// File: rtl/spi_flash_responder.sv
// SPI NOR flash responder: RDSR/WREN/WRDI/READ/PP/chip erase over a 2^MEM_AW byte array.
// Define FLASH_RESP_QUAD_EN to add the 0x6B quad-output read (8 dummy cycles, nibble per clk).
module spi_flash_responder #(
  parameter int MEM_AW      = 8,
  parameter int PROG_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flash_cs,
  input  logic       flash_si,
  output logic [3:0] flash_dq_out,
  output logic       flash_dq_oe,
  output logic       busy
);
`ifdef FLASH_RESP_QUAD_EN
  localparam bit QUAD_EN = 1'b1;
`else
  localparam bit QUAD_EN = 1'b0;
`endif
  localparam int CNT_W = $clog2(PROG_CYCLES + 1);

  localparam logic [7:0] CMD_WREN  = 8'h06;
  localparam logic [7:0] CMD_WRDI  = 8'h04;
  localparam logic [7:0] CMD_RDSR  = 8'h05;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_PP    = 8'h02;
  localparam logic [7:0] CMD_CE    = 8'hC7;
  localparam logic [7:0] CMD_QREAD = 8'h6B;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, READ, PROG, STATUS, IGNORE} state_t;
  typedef enum logic [1:0] {PEND_NONE, PEND_WREN, PEND_WRDI, PEND_CE} pend_t;

  state_t state, state_nxt;
  pend_t  pend, pend_nxt;

  logic [7:0]        mem [2**MEM_AW];
  logic [6:0]        shreg;
  logic [4:0]        bit_cnt;
  logic [MEM_AW-1:0] addr, erase_addr, addr_shift, addr_inc;
  logic [CNT_W-1:0]  prog_cnt;
  logic              wip, wel, erasing, prog_any, is_pp, quad, nib_lo;
  logic [7:0]        in_byte, status;
  logic              byte_done, pp_write;

  assign in_byte    = {shreg, flash_si};
  assign byte_done  = (bit_cnt[2:0] == 3'd7);
  assign addr_shift = MEM_AW'({addr, flash_si});
  assign addr_inc   = addr + MEM_AW'(1);
  assign status     = {6'b0, wel, wip};
  assign busy       = wip;
  assign pp_write   = !reset && !flash_cs && (state == PROG) && byte_done;

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    if (flash_cs) begin
      state_nxt = IDLE;
      pend_nxt  = PEND_NONE;
    end else begin
      case (state)
        IDLE: state_nxt = CMD;
        CMD: begin
          if (byte_done) begin
            // One-byte commands park in IGNORE; their effect is applied when cs rises.
            state_nxt = IGNORE;
            if (in_byte == CMD_RDSR) begin
              state_nxt = STATUS;
            end else if (!wip) begin
              case (in_byte)
                CMD_WREN:  pend_nxt = PEND_WREN;
                CMD_WRDI:  pend_nxt = PEND_WRDI;
                CMD_CE:    if (wel) pend_nxt = PEND_CE;
                CMD_READ:  state_nxt = ADDR;
                CMD_PP:    if (wel) state_nxt = ADDR;
                CMD_QREAD: if (QUAD_EN) state_nxt = ADDR;
                default:   state_nxt = IGNORE;
              endcase
            end
          end
        end
        ADDR: begin
          if (bit_cnt == 5'd23) state_nxt = is_pp ? PROG : (quad ? DUMMY : READ);
        end
        DUMMY: if (byte_done) state_nxt = READ;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pend         <= PEND_NONE;
      shreg        <= '0;
      bit_cnt      <= '0;
      addr         <= '0;
      erase_addr   <= '0;
      prog_cnt     <= '0;
      wip          <= 1'b0;
      wel          <= 1'b0;
      erasing      <= 1'b0;
      prog_any     <= 1'b0;
      is_pp        <= 1'b0;
      quad         <= 1'b0;
      nib_lo       <= 1'b0;
      flash_dq_out <= '0;
      flash_dq_oe  <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;

      if (erasing) begin
        erase_addr <= erase_addr + MEM_AW'(1);
        if (erase_addr == {MEM_AW{1'b1}}) begin
          erasing <= 1'b0;
          wip     <= 1'b0;
          wel     <= 1'b0;
        end
      end else if (wip) begin
        prog_cnt <= prog_cnt - CNT_W'(1);
        if (prog_cnt == CNT_W'(1)) wip <= 1'b0;
      end

      if (flash_cs) begin
        bit_cnt      <= '0;
        prog_any     <= 1'b0;
        flash_dq_oe  <= 1'b0;
        flash_dq_out <= '0;
        if (!wip) begin
          case (pend)
            PEND_WREN: wel <= 1'b1;
            PEND_WRDI: wel <= 1'b0;
            PEND_CE: begin
              wip        <= 1'b1;
              erasing    <= 1'b1;
              erase_addr <= '0;
            end
            default: ;
          endcase
          if (state == PROG && prog_any) begin
            wip      <= 1'b1;
            prog_cnt <= CNT_W'(PROG_CYCLES);
            wel      <= 1'b0;
          end
        end
      end else begin
        shreg <= in_byte[6:0];
        if (state == IDLE)           bit_cnt <= 5'd1;
        else if (state_nxt != state) bit_cnt <= '0;
        else                         bit_cnt <= bit_cnt + 5'd1;

        if (state == CMD && byte_done) begin
          is_pp <= (in_byte == CMD_PP);
          quad  <= QUAD_EN && (in_byte == CMD_QREAD);
        end
        if (state == ADDR) addr <= addr_shift;
        if (pp_write) begin
          addr     <= addr_inc;
          prog_any <= 1'b1;
        end

        // Outputs are registered: each edge presents the bit for the following cycle.
        case (state)
          CMD: if (state_nxt == STATUS) begin
            flash_dq_oe  <= 1'b1;
            flash_dq_out <= {2'b0, status[7], 1'b0};
          end
          STATUS: flash_dq_out <= {2'b0, status[3'd6 - bit_cnt[2:0]], 1'b0};
          ADDR: if (state_nxt == READ) begin
            flash_dq_oe  <= 1'b1;
            flash_dq_out <= {2'b0, mem[addr_shift][7], 1'b0};
          end
          DUMMY: if (QUAD_EN && state_nxt == READ) begin
            flash_dq_oe  <= 1'b1;
            flash_dq_out <= mem[addr][7:4];
            nib_lo       <= 1'b1;
          end
          READ: begin
            if (QUAD_EN && quad) begin
              nib_lo <= !nib_lo;
              if (nib_lo) begin
                flash_dq_out <= mem[addr][3:0];
              end else begin
                addr         <= addr_inc;
                flash_dq_out <= mem[addr_inc][7:4];
              end
            end else if (byte_done) begin
              addr         <= addr_inc;
              flash_dq_out <= {2'b0, mem[addr_inc][7], 1'b0};
            end else begin
              flash_dq_out <= {2'b0, mem[addr][3'd6 - bit_cnt[2:0]], 1'b0};
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Array has no reset so contents survive it; a sweep cut short keeps the bytes already erased.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (erasing)       mem[erase_addr] <= 8'hFF;
      else if (pp_write) mem[addr]       <= mem[addr] & in_byte;
    end
  end
endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: command table, hand-written corner sequences, random PP/READ vs model.
module tb_spi_flash_responder;
  localparam int MEM_AW      = 8;
  localparam int PROG_CYCLES = 16;
  localparam int MEM_SZ      = 1 << MEM_AW;
  localparam int K_CMD = 0, K_RDSR = 1, K_READ = 2, K_PP = 3;

  logic       clk = 1'b0;
  logic       reset, flash_cs, flash_si;
  logic [3:0] flash_dq_out;
  logic       flash_dq_oe, busy;

  spi_flash_responder #(.MEM_AW(MEM_AW), .PROG_CYCLES(PROG_CYCLES)) dut (
    .clk(clk), .reset(reset), .flash_cs(flash_cs), .flash_si(flash_si),
    .flash_dq_out(flash_dq_out), .flash_dq_oe(flash_dq_oe), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [7:0]  cmd;
    logic [23:0] addr;
    int          n;
    logic [7:0]  d0, d1, e0, e1;
    int          ebusy;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_mem [MEM_SZ];
  bit         model_wel = 1'b0;
  vec_t       vecs[$];
  logic       tx_q[$];
  logic [3:0] rx_dq[$];
  logic       rx_oe[$];
  logic       oe_after_rise;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic cs, input logic si);
    @(negedge clk);
    flash_cs = cs;
    flash_si = si;
    @(posedge clk);
    #1;
  endtask

  task automatic push_bits(input logic [31:0] v, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) tx_q.push_back(v[i]);
  endtask

  task automatic spi_run();
    rx_dq.delete();
    rx_oe.delete();
    while (tx_q.size() > 0) begin
      tick(1'b0, tx_q.pop_front());
      rx_dq.push_back(flash_dq_out);
      rx_oe.push_back(flash_dq_oe);
    end
    tick(1'b1, 1'b0);
    oe_after_rise = flash_dq_oe;
  endtask

  function automatic logic [7:0] rx_byte(input int start);
    logic [7:0] b;
    logic [3:0] t;
    for (int j = 0; j < 8; j++) begin
      t = rx_dq[start + j];
      b[7 - j] = t[1];
    end
    return b;
  endfunction

  task automatic busy_len(output int n);
    n = 0;
    while (busy && n < 400) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_cmd(input logic [7:0] c);
    if (c == 8'h06) model_wel = 1'b1;
    else if (c == 8'h04) model_wel = 1'b0;
    else if (c == 8'hC7 && model_wel) begin
      for (int i = 0; i < MEM_SZ; i++) model_mem[i] = 8'hFF;
      model_wel = 1'b0;
    end
  endtask

  function automatic int model_pp(input logic [23:0] a, input logic [7:0] d0, input logic [7:0] d1, input int n);
    if (!model_wel || n == 0) return 0;
    model_mem[int'(a) % MEM_SZ] &= d0;
    if (n > 1) model_mem[(int'(a) + 1) % MEM_SZ] &= d1;
    model_wel = 1'b0;
    return PROG_CYCLES;
  endfunction

  task automatic send_cmd(input logic [7:0] c);
    push_bits(32'(c), 8);
    spi_run();
    model_cmd(c);
  endtask

  task automatic rdsr(input string name, input logic [7:0] exp);
    push_bits(32'h05, 8);
    push_bits(32'h0, 16);
    spi_run();
    check({name, "_sr"}, rx_byte(7), exp);
    check({name, "_sr_rep"}, rx_byte(15), exp);
  endtask

  task automatic spi_read(input logic [23:0] a, input int n);
    push_bits(32'h03, 8);
    push_bits(32'(a), 24);
    push_bits(32'h0, 8 * n);
    spi_run();
  endtask

  function automatic void add(input int kind, input logic [7:0] cmd, input logic [23:0] addr, input int n,
                              input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] e0,
                              input logic [7:0] e1, input int ebusy);
    vec_t v;
    v.kind = kind; v.cmd = cmd; v.addr = addr; v.n = n;
    v.d0 = d0; v.d1 = d1; v.e0 = e0; v.e1 = e1; v.ebusy = ebusy;
    vecs.push_back(v);
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int    n, eb;
    string nm;
    nm = $sformatf("vec%0d", idx);
    case (v.kind)
      K_CMD: begin
        send_cmd(v.cmd);
        busy_len(n);
        if (v.ebusy >= MEM_SZ) begin
          checks++;
          if (n < v.ebusy || n > v.ebusy + 2) begin
            errors++;
            $display("FAIL %s_erase_busy: got %0d cycles, expected %0d..%0d", nm, n, v.ebusy, v.ebusy + 2);
          end
        end else begin
          check({nm, "_busy"}, n, v.ebusy);
        end
      end
      K_RDSR: rdsr(nm, v.e0);
      K_READ: begin
        spi_read(v.addr, v.n);
        check({nm, "_oe_pre"}, rx_oe[30], 1'b0);
        check({nm, "_oe_first"}, rx_oe[31], 1'b1);
        check({nm, "_b0"}, rx_byte(31), v.e0);
        if (v.n > 1) check({nm, "_b1"}, rx_byte(39), v.e1);
        check({nm, "_oe_drop"}, oe_after_rise, 1'b0);
      end
      default: begin
        push_bits(32'h02, 8);
        push_bits(32'(v.addr), 24);
        push_bits(32'(v.d0), 8);
        if (v.n > 1) push_bits(32'(v.d1), 8);
        spi_run();
        busy_len(n);
        eb = model_pp(v.addr, v.d0, v.d1, v.n);
        check({nm, "_busy_model"}, n, eb);
        check({nm, "_busy"}, n, v.ebusy);
      end
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, any_oe, any_dq, k;
    logic [23:0] a;
    logic [7:0]  d0, d1;

    reset = 1'b1; flash_cs = 1'b1; flash_si = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_oe", flash_dq_oe, 1'b0);
    check("rst_dq", flash_dq_out, 4'h0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk) reset = 1'b0;

    add(K_RDSR, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    add(K_CMD, 8'h06, 0, 0, 0, 0, 0, 0, 0);
    add(K_RDSR, 0, 0, 0, 0, 0, 8'h02, 0, 0);
    add(K_CMD, 8'h04, 0, 0, 0, 0, 0, 0, 0);
    add(K_RDSR, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    add(K_CMD, 8'h06, 0, 0, 0, 0, 0, 0, 0);
    add(K_CMD, 8'hC7, 0, 0, 0, 0, 0, 0, MEM_SZ);
    add(K_RDSR, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    add(K_READ, 0, 24'h000010, 2, 0, 0, 8'hFF, 8'hFF, 0);
    add(K_PP, 0, 24'h0000BB, 2, 8'h8C, 8'hEF, 0, 0, 0);
    add(K_READ, 0, 24'h0000BB, 2, 0, 0, 8'hFF, 8'hFF, 0);
    add(K_CMD, 8'h06, 0, 0, 0, 0, 0, 0, 0);
    add(K_PP, 0, 24'h00EEBB, 2, 8'h8C, 8'hEF, 0, 0, PROG_CYCLES);
    add(K_RDSR, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    add(K_READ, 0, 24'h00EEBB, 2, 0, 0, 8'h8C, 8'hEF, 0);
    add(K_CMD, 8'h06, 0, 0, 0, 0, 0, 0, 0);
    add(K_PP, 0, 24'h0000FF, 2, 8'h5A, 8'h3C, 0, 0, PROG_CYCLES);
    add(K_READ, 0, 24'h0000FF, 2, 0, 0, 8'h5A, 8'h3C, 0);
    add(K_CMD, 8'h06, 0, 0, 0, 0, 0, 0, 0);
    add(K_PP, 0, 24'h00FF00, 1, 8'hF0, 0, 0, 0, PROG_CYCLES);
    add(K_READ, 0, 24'hAB0000, 1, 0, 0, 8'h30, 0, 0);
    add(K_CMD, 8'hC7, 0, 0, 0, 0, 0, 0, 0);
    add(K_READ, 0, 24'h00EEBC, 1, 0, 0, 8'hEF, 0, 0);
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // 0x6B: quad read when enabled, otherwise an unknown command that never drives the bus.
    push_bits(32'h6B, 8);
    push_bits(32'h00EEBB, 24);
    push_bits(32'h0, 32);
    spi_run();
`ifdef FLASH_RESP_QUAD_EN
    check("quad_oe_pre", rx_oe[38], 1'b0);
    check("quad_n0", rx_dq[39], model_mem[8'hBB][7:4]);
    check("quad_n1", rx_dq[40], model_mem[8'hBB][3:0]);
    check("quad_n2", rx_dq[41], model_mem[8'hBC][7:4]);
    check("quad_n3", rx_dq[42], model_mem[8'hBC][3:0]);
`else
    any_oe = 0; any_dq = 0;
    for (int i = 0; i < rx_oe.size(); i++) begin
      if (rx_oe[i]) any_oe++;
      if (rx_dq[i] != 4'h0) any_dq++;
    end
    check("qread_ignored_oe", any_oe, 0);
    check("qread_ignored_dq", any_dq, 0);
`endif

    // PP cut off after 5 data bits: nothing written, no busy period.
    send_cmd(8'h06);
    push_bits(32'h02, 8);
    push_bits(32'h000040, 24);
    push_bits(32'h0, 5);
    spi_run();
    busy_len(n);
    check("partial_pp_busy", n, 0);
    send_cmd(8'h04);
    spi_read(24'h000040, 1);
    check("partial_pp_mem", rx_byte(31), model_mem[8'h40]);

    for (int it = 0; it < 16; it++) begin
      a = 24'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        k  = $urandom_range(1, 2);
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        send_cmd(8'h06);
        push_bits(32'h02, 8);
        push_bits(32'(a), 24);
        push_bits(32'(d0), 8);
        if (k > 1) push_bits(32'(d1), 8);
        spi_run();
        busy_len(n);
        check($sformatf("rnd%0d_pp_busy", it), n, model_pp(a, d0, d1, k));
      end else begin
        k = $urandom_range(1, 4);
        spi_read(a, k);
        for (int b = 0; b < k; b++)
          check($sformatf("rnd%0d_rd%0d", it, b), rx_byte(31 + 8 * b), model_mem[(int'(a) + b) % MEM_SZ]);
      end
    end

    // Erase in progress: RDSR still answers, READ is ignored.
    send_cmd(8'h06);
    send_cmd(8'hC7);
    rdsr("erase_wip", 8'h03);
    spi_read(24'h000010, 2);
    any_oe = 0;
    for (int i = 0; i < rx_oe.size(); i++) if (rx_oe[i]) any_oe++;
    check("read_during_wip_oe", any_oe, 0);
    busy_len(n);
    check("erase_done_busy", busy, 1'b0);
    rdsr("erase_done", 8'h00);

    // Reset mid-erase: busy drops at once, erased prefix and untouched bytes both readable.
    send_cmd(8'h06);
    push_bits(32'h02, 8); push_bits(32'h000005, 24); push_bits(32'h00, 8);
    spi_run(); busy_len(n);
    send_cmd(8'h06);
    push_bits(32'h02, 8); push_bits(32'h0000C0, 24); push_bits(32'h12, 8);
    spi_run(); busy_len(n);
    send_cmd(8'h06);
    send_cmd(8'hC7);
    repeat (20) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("erase_rst_busy", busy, 1'b0);
    check("erase_rst_oe", flash_dq_oe, 1'b0);
    @(negedge clk) reset = 1'b0;
    spi_read(24'h000005, 1);
    check("erase_rst_erased", rx_byte(31), 8'hFF);
    spi_read(24'h0000C0, 1);
    check("erase_rst_kept", rx_byte(31), 8'h12);
    rdsr("erase_rst", 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
